// File: rtl/instr_encode_writer.sv
// Encodes instruction requests into 32-bit ISA words, queues them in a small FIFO
// and writes them to consecutive instruction-memory addresses.
module instr_encode_writer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              empty,
  output logic              err_illegal
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state, next_state;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              full, fifo_empty, accept, push, pop;

  // Unused fields of each format are zero-filled so decode of the stored word
  // matches the requested kind exactly.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_kind)
      4'd0:  enc_word = {5'b00000, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      4'd1:  enc_word = {5'b00101, in_rd, in_rs, in_imm};
      4'd2:  enc_word = {5'b01000, in_rd, in_rs, in_imm};
      4'd3:  enc_word = {5'b00111, in_rd, in_rs, in_imm};
      4'd4:  enc_word = {5'b00001, in_target};
      4'd5:  enc_word = {5'b00010, in_rd, in_rs, in_imm};
      4'd6:  enc_word = {5'b00011, in_target};
      4'd7:  enc_word = {5'b00100, in_rd, 22'd0};
      4'd8:  enc_word = {5'b00110, in_rd, in_rs, in_imm};
      4'd9:  enc_word = {5'b10110, in_target};
      4'd10: enc_word = {5'b10101, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign full       = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign empty      = fifo_empty;
  assign in_ready   = ~full & ~restart;
  assign accept     = in_valid & in_ready;
  assign push       = accept & enc_legal;
  assign pop        = ~fifo_empty & ~imem_busy & ~restart;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    if (pop) next_state = WRITE;
  end

  assign imem_we = (state == WRITE);

  // imem_addr/imem_data hold the last write; addr_cnt is the next free address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_cnt  <= BASE;
      imem_addr <= BASE;
      imem_data <= '0;
    end else if (restart) begin
      addr_cnt  <= BASE;
      imem_addr <= BASE;
      imem_data <= '0;
    end else if (pop) begin
      imem_addr <= addr_cnt;
      imem_data <= mem[rd_ptr];
      addr_cnt  <= addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     err_illegal <= 1'b0;
    else if (restart)               err_illegal <= 1'b0;
    else if (accept && !enc_legal)  err_illegal <= 1'b1;
  end

endmodule
